// File: rtl/div_unit_if.sv
// Handshake/operand bundle between the EX-stage issue logic and the iterative divider.
//   start, signed_div, flush, dividend, divisor : requester -> divider
//   busy, done, quotient, remainder              : divider -> requester
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic             flush;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_div, flush, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, signed_div, flush, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : div_unit_if.slave (start/signed_div/flush/dividend/divisor in,
//          busy/done/quotient(LO)/remainder(HI) out)
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs_q, dvs_d;     // |divisor|
    logic [WIDTH-1:0]   prem_q, prem_d;   // partial remainder
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dz_q, dz_d;       // divide by zero: quotient bypasses sign fix
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   prem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               last_iter;

    // One restoring step: shift in next dividend bit, trial-subtract |divisor|.
    always_comb begin
        shifted   = {prem_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        qbit      = ~diff[WIDTH];
        prem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_step  = {dvd_q[WIDTH-2:0], qbit};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Operand magnitudes; unsigned requests pass straight through.
    always_comb begin
        a_neg = bus.signed_div & bus.dividend[WIDTH-1];
        b_neg = bus.signed_div & bus.divisor[WIDTH-1];
        abs_a = a_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        abs_b = b_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    prem_d  = '0;
                    dvd_d   = abs_a;
                    dvs_d   = abs_b;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    dz_d    = (bus.divisor == '0);
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    dvd_d  = quo_step;
                    prem_d = prem_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        // Results land in the output registers on entry to DONE.
                        // With a zero divisor the magnitude path already yields
                        // all-ones / |dividend|; re-signing the remainder restores
                        // the raw dividend, the quotient is left alone.
                        state_d = S_DONE;
                        quo_d   = (q_neg_q && !dz_q) ? (~quo_step + WIDTH'(1)) : quo_step;
                        rem_d   = r_neg_q ? (~prem_step + WIDTH'(1)) : prem_step;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
endmodule
